// File: rtl/sbox_sched.sv
// sbox_sched: one 4-lane S-box bank shared by the SubBytes state path and the SubWord key path; `define SBOX_SCHED_ROTWORD_EN to apply RotWord before SubWord
module sbox_sched (
  input  logic         clk,
  input  logic         rst,
  input  logic         st_in_valid,
  input  logic [127:0] st_in,
  output logic         st_in_ready,
  input  logic         kw_in_valid,
  input  logic [31:0]  kw_in,
  output logic         kw_in_ready,
  output logic [127:0] st_out,
  output logic         st_out_valid,
  output logic [31:0]  kw_out,
  output logic         kw_out_valid
);
  typedef enum logic [1:0] {IDLE, ST_BUSY, KW_BUSY} state_e;
  state_e       state_q, state_d;
  logic [1:0]   beat_q, beat_d;
  logic         last_kw_q, last_kw_d;
  logic [127:0] st_buf_q, st_buf_d, st_out_q, st_out_d;
  logic [31:0]  kw_buf_q, kw_buf_d, kw_out_q, kw_out_d, kw_word, bank_in, bank_out;
  logic         st_vld_q, st_vld_d, kw_vld_q, kw_vld_d, st_hs, kw_hs;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // inverse is a^254 by square-and-multiply (0 maps to 0), then the AES affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq, inv;
    sq = a;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

`ifdef SBOX_SCHED_ROTWORD_EN
  assign kw_word = {kw_buf_q[23:0], kw_buf_q[31:24]};
`else
  assign kw_word = kw_buf_q;
`endif

  assign st_out       = st_out_q;
  assign st_out_valid = st_vld_q;
  assign kw_out       = kw_out_q;
  assign kw_out_valid = kw_vld_q;

  // state register and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      last_kw_q <= 1'b0;
      st_buf_q  <= '0;
      kw_buf_q  <= '0;
      st_out_q  <= '0;
      kw_out_q  <= '0;
      st_vld_q  <= 1'b0;
      kw_vld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      last_kw_q <= last_kw_d;
      st_buf_q  <= st_buf_d;
      kw_buf_q  <= kw_buf_d;
      st_out_q  <= st_out_d;
      kw_out_q  <= kw_out_d;
      st_vld_q  <= st_vld_d;
      kw_vld_q  <= kw_vld_d;
    end
  end

  // grants only from IDLE; jobs run to completion without preemption
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    last_kw_d = last_kw_q;
    case (state_q)
      IDLE:
        if (st_hs) begin
          state_d   = ST_BUSY;
          beat_d    = '0;
          last_kw_d = 1'b0;
        end else if (kw_hs) begin
          state_d   = KW_BUSY;
          last_kw_d = 1'b1;
        end
      ST_BUSY: begin
        beat_d  = beat_q + 2'd1;
        state_d = (beat_q == 2'd3) ? IDLE : ST_BUSY;
      end
      default: state_d = IDLE;
    endcase
  end

  // handshakes with alternating priority, bank input mux and result write-back
  always_comb begin
    st_in_ready = (state_q == IDLE) & (!kw_in_valid | last_kw_q);
    kw_in_ready = (state_q == IDLE) & (!st_in_valid | !last_kw_q);
    st_hs       = st_in_valid & st_in_ready;
    kw_hs       = kw_in_valid & kw_in_ready;
    bank_in     = (state_q == ST_BUSY) ? st_buf_q[{~beat_q, 5'b0} +: 32] : (state_q == KW_BUSY) ? kw_word : '0;
    bank_out    = {sbox(bank_in[31:24]), sbox(bank_in[23:16]), sbox(bank_in[15:8]), sbox(bank_in[7:0])};
    st_buf_d    = st_hs ? st_in : st_buf_q;
    kw_buf_d    = kw_hs ? kw_in : kw_buf_q;
    kw_out_d    = (state_q == KW_BUSY) ? bank_out : kw_out_q;
    st_vld_d    = (state_q == ST_BUSY) & (beat_q == 2'd3);
    kw_vld_d    = (state_q == KW_BUSY);
    st_out_d    = st_out_q;
    if (state_q == ST_BUSY) st_out_d[{~beat_q, 5'b0} +: 32] = bank_out;
  end
endmodule

// File: tb/tb_sbox_sched.sv
// tb_sbox_sched: directed scoreboard bench for sbox_sched (honours SBOX_SCHED_ROTWORD_EN)
module tb_sbox_sched;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         st_in_valid = 1'b0;
  logic [127:0] st_in = '0;
  logic         st_in_ready;
  logic         kw_in_valid = 1'b0;
  logic [31:0]  kw_in = '0;
  logic         kw_in_ready;
  logic [127:0] st_out;
  logic         st_out_valid;
  logic [31:0]  kw_out;
  logic         kw_out_valid;

  int checks = 0, failures = 0, cyc = 0, c0 = 0, saved = 0;
  int st_hs_cyc = -1, kw_hs_cyc = -1, st_pulse_cyc = -1, kw_pulse_cyc = -1, st_pulses = 0, kw_pulses = 0;
  logic [127:0] st_sb[$];
  logic [31:0]  kw_sb[$];
  logic [127:0] st_exp_v = '0;
  logic [31:0]  kw_exp_v = '0;

  localparam logic [127:0] ST_A  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] ST_AX = 128'h638293c31bfc33f5c4eeacea4bc12816;
  localparam logic [127:0] ST_Z  = 128'h0;
  localparam logic [127:0] ST_ZX = {16{8'h63}};
  localparam logic [127:0] ST_F  = {16{8'hff}};
  localparam logic [127:0] ST_FX = {16{8'h16}};
  localparam logic [31:0]  KW_A  = 32'h09cf4f3c;
  localparam logic [31:0]  KW_B  = 32'h00112233;
`ifdef SBOX_SCHED_ROTWORD_EN
  localparam logic [31:0]  KW_AX = 32'h8a84eb01;
  localparam logic [31:0]  KW_BX = 32'h8293c363;
`else
  localparam logic [31:0]  KW_AX = 32'h018a84eb;
  localparam logic [31:0]  KW_BX = 32'h638293c3;
`endif

  sbox_sched dut (
    .clk(clk), .rst(rst),
    .st_in_valid(st_in_valid), .st_in(st_in), .st_in_ready(st_in_ready),
    .kw_in_valid(kw_in_valid), .kw_in(kw_in), .kw_in_ready(kw_in_ready),
    .st_out(st_out), .st_out_valid(st_out_valid),
    .kw_out(kw_out), .kw_out_valid(kw_out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    #2;
    if (!rst && st_in_valid && st_in_ready) begin st_sb.push_back(st_exp_v); st_hs_cyc = cyc; end
    if (!rst && kw_in_valid && kw_in_ready) begin kw_sb.push_back(kw_exp_v); kw_hs_cyc = cyc; end
    @(posedge clk);
    #1;
    cyc++;
    chk("never_both_valid", 128'(st_out_valid & kw_out_valid), 128'(0));
    if (st_out_valid) begin
      st_pulses++;
      st_pulse_cyc = cyc;
      chk("st_expected_pending", 128'(st_sb.size() != 0), 128'(1));
      if (st_sb.size() != 0) chk("st_out", st_out, st_sb.pop_front());
    end
    if (kw_out_valid) begin
      kw_pulses++;
      kw_pulse_cyc = cyc;
      chk("kw_expected_pending", 128'(kw_sb.size() != 0), 128'(1));
      if (kw_sb.size() != 0) chk("kw_out", 128'(kw_out), 128'(kw_sb.pop_front()));
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    st_in_valid = 1'b0;
    kw_in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    st_sb.delete();
    kw_sb.delete();
    st_hs_cyc = -1; kw_hs_cyc = -1; st_pulse_cyc = -1; kw_pulse_cyc = -1;
  endtask

  initial begin
    do_reset();
    #1;
    chk("rst_st_out", st_out, '0);
    chk("rst_kw_out", 128'(kw_out), '0);
    chk("rst_st_valid", 128'(st_out_valid), '0);
    chk("rst_kw_valid", 128'(kw_out_valid), '0);
    chk("rst_st_ready", 128'(st_in_ready), 128'(1));
    chk("rst_kw_ready", 128'(kw_in_ready), 128'(1));

    st_in = ST_A; st_exp_v = ST_AX; st_in_valid = 1'b1;
    c0 = cyc;
    tick();
    st_in_valid = 1'b0; st_in = '1;
    #1 chk("st_busy_not_ready", 128'(st_in_ready), '0);
    repeat (5) tick();
    chk("st_hs_cyc", 128'(st_hs_cyc), 128'(c0));
    chk("st_latency", 128'(st_pulse_cyc), 128'(c0 + 5));
    chk("st_pulse_width", 128'(st_out_valid), '0);
    chk("st_out_holds", st_out, ST_AX);

    kw_in = KW_A; kw_exp_v = KW_AX; kw_in_valid = 1'b1;
    c0 = cyc;
    tick();
    kw_in_valid = 1'b0; kw_in = '0;
    repeat (3) tick();
    chk("kw_latency", 128'(kw_pulse_cyc), 128'(c0 + 2));
    chk("kw_out_holds", 128'(kw_out), 128'(KW_AX));

    do_reset();
    st_in = ST_A; st_exp_v = ST_AX; st_in_valid = 1'b1;
    kw_in = KW_A; kw_exp_v = KW_AX; kw_in_valid = 1'b1;
    c0 = cyc;
    tick();
    chk("sim_kw_first", 128'(kw_hs_cyc), 128'(c0));
    chk("sim_st_waits", 128'(st_hs_cyc), 128'(-1));
    kw_in = KW_B; kw_exp_v = KW_BX;
    tick();
    chk("sim_kw1_pulse", 128'(kw_pulse_cyc), 128'(c0 + 2));
    tick();
    chk("sim_st_grant", 128'(st_hs_cyc), 128'(c0 + 2));
    repeat (5) tick();
    chk("sim_st_pulse", 128'(st_pulse_cyc), 128'(c0 + 7));
    chk("sim_kw2_grant", 128'(kw_hs_cyc), 128'(c0 + 7));
    st_in_valid = 1'b0; kw_in_valid = 1'b0;
    repeat (2) tick();
    chk("sim_kw2_pulse", 128'(kw_pulse_cyc), 128'(c0 + 9));

    st_in = ST_A; st_exp_v = ST_AX; st_in_valid = 1'b1;
    c0 = cyc;
    tick();
    st_in_valid = 1'b0;
    tick();
    kw_in = KW_A; kw_exp_v = KW_AX; kw_in_valid = 1'b1;
    #1 chk("wait_ready_c2", 128'(kw_in_ready), '0);
    tick();
    chk("wait_ready_c3", 128'(kw_in_ready), '0);
    tick();
    chk("wait_ready_c4", 128'(kw_in_ready), '0);
    tick();
    chk("wait_ready_c5", 128'(kw_in_ready), 128'(1));
    tick();
    kw_in_valid = 1'b0;
    chk("wait_kw_grant", 128'(kw_hs_cyc), 128'(c0 + 5));
    chk("wait_st_pulse", 128'(st_pulse_cyc), 128'(c0 + 5));
    repeat (2) tick();
    chk("wait_kw_pulse", 128'(kw_pulse_cyc), 128'(c0 + 7));
    chk("wait_st_intact", st_out, ST_AX);

    st_in = ST_F; st_exp_v = ST_FX; st_in_valid = 1'b1;
    saved = st_pulses;
    tick();
    st_in_valid = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    st_sb.delete();
    chk("abort_st_out", st_out, '0);
    chk("abort_kw_out", 128'(kw_out), '0);
    chk("abort_idle", 128'(st_in_ready), 128'(1));
    repeat (4) tick();
    chk("abort_no_pulse", 128'(st_pulses), 128'(saved));
    st_in = ST_A; st_exp_v = ST_AX; st_in_valid = 1'b1;
    c0 = cyc;
    tick();
    st_in_valid = 1'b0;
    repeat (5) tick();
    chk("abort_fresh_pulse", 128'(st_pulse_cyc), 128'(c0 + 5));
    chk("abort_fresh_out", st_out, ST_AX);

    st_in = ST_Z; st_exp_v = ST_ZX; st_in_valid = 1'b1;
    c0 = cyc;
    tick();
    st_in = ST_F; st_exp_v = ST_FX;
    repeat (4) tick();
    chk("b2b_first_pulse", 128'(st_pulse_cyc), 128'(c0 + 5));
    chk("b2b_first_out", st_out, ST_ZX);
    tick();
    st_in_valid = 1'b0;
    chk("b2b_second_grant", 128'(st_hs_cyc), 128'(c0 + 5));
    repeat (5) tick();
    chk("b2b_second_pulse", 128'(st_pulse_cyc), 128'(c0 + 10));
    chk("b2b_second_out", st_out, ST_FX);
    chk("sb_st_drained", 128'(st_sb.size()), '0);
    chk("sb_kw_drained", 128'(kw_sb.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
